// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: time-shares one combinational ALU between N_REQ requesters.
//
// One operation is in flight at a time. The FSM walks IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: pick a valid requester, complete its request handshake and register op/a/b.
//   EXEC: the ALU sees only the registered operands; its outputs are registered at the edge.
//   RESP: the result/flag is held on the shared response bus until the owner accepts it.
//
// Arbitration is round-robin. The pointer advances only after a completed response.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority, where the lowest index
// always wins and the pointer is tied to 0.
//
// ALU op encoding ({class[1:0], funct[2:0]}):
//   00_000 ADD   00_001 SLL   00_010 SLT   00_011 SLTU  00_100 XOR  00_101 SRL
//   00_110 OR    00_111 AND   01_000 SUB   01_101 SRA
//   11_000 EQ    11_001 NE    11_100 LT    11_101 GE    11_110 LTU  11_111 GEU
//   Compares drive flag and return {31'b0, flag} as the result. Other ops leave flag at 0.
//   Undefined codes give result 0 and flag 0.
//
// Ports:
//   clk_i, rst_i   clock and asynchronous active-high reset
//   req_valid_i    per-requester request valid
//   req_ready_o    per-requester accept (at most one bit set)
//   req_op_i       packed 5-bit ops, requester k at [5k+4:5k]
//   req_a_i/b_i    packed 32-bit operands, requester k at [32k+31:32k]
//   rsp_valid_o    one-hot response valid (owning requester)
//   rsp_ready_i    per-requester response accept (only the owner's bit is used)
//   rsp_result_o   registered ALU result
//   rsp_flag_o     registered ALU flag
//   busy_o         high whenever an operation is in flight
module alu_share_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned PTR_W = $clog2(N_REQ)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_REQ-1:0]    req_valid_i,
  output logic [N_REQ-1:0]    req_ready_o,
  input  logic [N_REQ*5-1:0]  req_op_i,
  input  logic [N_REQ*32-1:0] req_a_i,
  input  logic [N_REQ*32-1:0] req_b_i,
  output logic [N_REQ-1:0]    rsp_valid_o,
  input  logic [N_REQ-1:0]    rsp_ready_i,
  output logic [31:0]         rsp_result_o,
  output logic                rsp_flag_o,
  output logic                busy_o
);

  localparam logic [4:0] OpAdd  = 5'b00000;
  localparam logic [4:0] OpSll  = 5'b00001;
  localparam logic [4:0] OpSlt  = 5'b00010;
  localparam logic [4:0] OpSltu = 5'b00011;
  localparam logic [4:0] OpXor  = 5'b00100;
  localparam logic [4:0] OpSrl  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpAnd  = 5'b00111;
  localparam logic [4:0] OpSub  = 5'b01000;
  localparam logic [4:0] OpSra  = 5'b01101;
  localparam logic [4:0] OpEq   = 5'b11000;
  localparam logic [4:0] OpNe   = 5'b11001;
  localparam logic [4:0] OpLt   = 5'b11100;
  localparam logic [4:0] OpGe   = 5'b11101;
  localparam logic [4:0] OpLtu  = 5'b11110;
  localparam logic [4:0] OpGeu  = 5'b11111;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e             state_q;
  logic [PTR_W-1:0]   grant_q;
  logic [4:0]         op_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [31:0]        rsp_result_q;
  logic               rsp_flag_q;
  logic [N_REQ-1:0]   rsp_valid_q;
  logic               busy_q;

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   sel;
  logic               sel_found;
  logic [N_REQ-1:0]   grant_onehot;
  logic [31:0]        alu_result;
  logic               alu_flag;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [PTR_W-1:0]   ptr_q;
  assign ptr = ptr_q;
`endif

  // Scan offsets from farthest to nearest so the requester closest to ptr wins.
  always_comb begin
    int idx;
    idx       = 0;
    sel       = '0;
    sel_found = 1'b0;
    for (int off = int'(N_REQ) - 1; off >= 0; off--) begin
      idx = (int'(ptr) + off) % int'(N_REQ);
      if (req_valid_i[idx]) begin
        sel       = PTR_W'(idx);
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (state_q == StIdle && sel_found) begin
      req_ready_o[sel] = 1'b1;
    end
  end

  assign grant_onehot = N_REQ'(1) << grant_q;

  // The shared ALU, fed only from the registered operands.
  always_comb begin
    alu_result = '0;
    alu_flag   = 1'b0;
    case (op_q)
      OpAdd:   alu_result = a_q + b_q;
      OpSll:   alu_result = a_q << b_q[4:0];
      OpSlt:   alu_result = {31'b0, ($signed(a_q) < $signed(b_q))};
      OpSltu:  alu_result = {31'b0, (a_q < b_q)};
      OpXor:   alu_result = a_q ^ b_q;
      OpSrl:   alu_result = a_q >> b_q[4:0];
      OpOr:    alu_result = a_q | b_q;
      OpAnd:   alu_result = a_q & b_q;
      OpSub:   alu_result = a_q - b_q;
      OpSra:   alu_result = $unsigned($signed(a_q) >>> b_q[4:0]);
      OpEq:    alu_flag   = (a_q == b_q);
      OpNe:    alu_flag   = (a_q != b_q);
      OpLt:    alu_flag   = ($signed(a_q) < $signed(b_q));
      OpGe:    alu_flag   = ($signed(a_q) >= $signed(b_q));
      OpLtu:   alu_flag   = (a_q < b_q);
      OpGeu:   alu_flag   = (a_q >= b_q);
      default: ;
    endcase
    if (op_q[4:3] == 2'b11) begin
      alu_result = {31'b0, alu_flag};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_result_q <= '0;
      rsp_flag_q   <= 1'b0;
      rsp_valid_q  <= '0;
      busy_q       <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q        <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (sel_found) begin
            grant_q <= sel;
            op_q    <= req_op_i[5*int'(sel) +: 5];
            a_q     <= req_a_i[32*int'(sel) +: 32];
            b_q     <= req_b_i[32*int'(sel) +: 32];
            busy_q  <= 1'b1;
            state_q <= StExec;
          end
        end
        StExec: begin
          rsp_result_q <= alu_result;
          rsp_flag_q   <= alu_flag;
          rsp_valid_q  <= grant_onehot;
          state_q      <= StResp;
        end
        StResp: begin
          // rsp_valid_q is one-hot on the owner, so other requesters' ready bits drop out.
          if (|(rsp_ready_i & rsp_valid_q)) begin
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr_q       <= (grant_q == PTR_W'(N_REQ - 1)) ? '0 : grant_q + PTR_W'(1);
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_flag_o   = rsp_flag_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: directed cases plus randomized traffic on a 2-requester
// instance, and a round-robin wrap case on a 3-requester instance.
module tb_alu_share_arbiter;

  localparam int N = 2;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*5-1:0]  req_op;
  logic [N*32-1:0] req_a, req_b;
  logic [31:0]     rsp_result;
  logic            rsp_flag, busy;

  logic [2:0]      valid3, ready3, rv3, rr3;
  logic [14:0]     op3;
  logic [95:0]     a3, b3;
  logic [31:0]     res3;
  logic            flag3, busy3;

  alu_share_arbiter #(.N_REQ(N)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_flag_o(rsp_flag), .busy_o(busy)
  );

  alu_share_arbiter #(.N_REQ(3)) dut3 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(valid3), .req_ready_o(ready3),
    .req_op_i(op3), .req_a_i(a3), .req_b_i(b3),
    .rsp_valid_o(rv3), .rsp_ready_i(rr3),
    .rsp_result_o(res3), .rsp_flag_o(flag3), .busy_o(busy3)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference ALU: returns {flag, result}.
  function automatic logic [32:0] model_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    logic f;
    int sh;
    r = '0;
    f = 1'b0;
    sh = int'(b[4:0]);
    case (op)
      5'b00000: r = a + b;
      5'b00001: r = a << sh;
      5'b00010: r = {31'b0, ($signed(a) < $signed(b))};
      5'b00011: r = {31'b0, (a < b)};
      5'b00100: r = a ^ b;
      5'b00101: r = a >> sh;
      5'b00110: r = a | b;
      5'b00111: r = a & b;
      5'b01000: r = a - b;
      5'b01101: r = $unsigned($signed(a) >>> sh);
      5'b11000: f = (a == b);
      5'b11001: f = (a != b);
      5'b11100: f = ($signed(a) < $signed(b));
      5'b11101: f = ($signed(a) >= $signed(b));
      5'b11110: f = (a < b);
      5'b11111: f = (a >= b);
      default: ;
    endcase
    if (op[4:3] == 2'b11) r = {31'b0, f};
    return {f, r};
  endfunction

  // First valid requester scanning ptr, ptr+1, ... modulo n; -1 if none.
  function automatic int pick(input logic [7:0] v, input int ptr, input int n);
    for (int off = 0; off < n; off++) begin
      if (v[(ptr + off) % n]) return (ptr + off) % n;
    end
    return -1;
  endfunction

  function automatic int idx_of(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  typedef struct packed {
    logic [31:0] result;
    logic        flag;
    logic [2:0]  grant;
  } exp_t;

  exp_t exp_q[$];

  // Transaction model: decides which request is accepted, pushes the expected response,
  // and tracks when the owner's response should be visible.
  bit m_busy = 1'b0;
  int m_grant = 0;
  int m_age = 0;
  int m_ptr = 0;

  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rv;
    logic [32:0]  r;
    exp_t e;
    int g;
    if (rst) begin
      m_busy = 1'b0;
      m_ptr  = 0;
      m_age  = 0;
      exp_q.delete();
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_busy", busy, 0);
    end else begin
      g = m_busy ? -1 : pick(8'(req_valid), m_ptr, N);
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      check("req_ready", req_ready, exp_ready);
      check("busy", busy, m_busy);
      exp_rv = '0;
      if (m_busy && m_age >= 1) exp_rv[m_grant] = 1'b1;
      check("rsp_valid_timing", rsp_valid, exp_rv);
      if (m_busy && m_age >= 1) begin
        if (rsp_ready[m_grant]) begin
          m_busy = 1'b0;
          m_ptr  = FIXED ? 0 : (m_grant + 1) % N;
        end
      end else if (m_busy) begin
        m_age++;
      end else if (g >= 0) begin
        r = model_alu(req_op[5*g +: 5], req_a[32*g +: 32], req_b[32*g +: 32]);
        e.result = r[31:0];
        e.flag   = r[32];
        e.grant  = 3'(g);
        exp_q.push_back(e);
        m_busy  = 1'b1;
        m_grant = g;
        m_age   = 0;
      end
    end
  end

  // Response monitor: compares every presented response against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    logic [N-1:0] oh;
    if (!rst && rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got rsp_valid=%b expected no response", rsp_valid);
      end else begin
        e = exp_q[0];
        oh = '0;
        oh[e.grant] = 1'b1;
        check("rsp_owner", rsp_valid, oh);
        check("rsp_result", rsp_result, e.result);
        check("rsp_flag", rsp_flag, e.flag);
        if ((rsp_valid & rsp_ready) != '0) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_valid[k]         = 1'b1;
    req_op[5*k +: 5]     = op;
    req_a[32*k +: 32]    = a;
    req_b[32*k +: 32]    = b;
  endtask

  // Returns one cycle after the accepting edge (DUT in its execute cycle).
  task automatic wait_accept(input int k);
    int n;
    n = 0;
    #1;
    while (!(req_ready[k] && req_valid[k]) && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL accept_timeout: requester %0d got no ready, required ready within 20", k);
    end
    tick();
    req_valid[k] = 1'b0;
  endtask

  logic [4:0] op_list [16];
  logic [N-1:0] acc;
  int got, n;

  initial begin
    op_list = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
                5'b00111, 5'b01000, 5'b01101, 5'b11000, 5'b11001, 5'b11100, 5'b11101,
                5'b11110, 5'b11111};
    rst = 1'b1;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    valid3 = '0; op3 = '0; a3 = '0; b3 = '0; rr3 = '0;
    tick();
    check("reset_result", rsp_result, 0);
    check("reset_flag", rsp_flag, 0);
    check("reset_busy_init", busy, 0);
    tick();
    rst = 1'b0;
    tick();

    // Single ADD with a held response.
    set_req(0, 5'b00000, 32'd7, 32'd5);
    #1;
    check("add_ready_same_cycle", req_ready, 2'b01);
    wait_accept(0);
    check("add_exec_no_rsp", rsp_valid, 2'b00);
    tick();
    check("add_rsp_valid", rsp_valid, 2'b01);
    check("add_result", rsp_result, 32'd12);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("add_hold_result", rsp_result, 32'd12);
    end
    rsp_ready = 2'b01;
    tick();
    check("add_busy_falls", busy, 1'b0);
    rsp_ready = 2'b00;

    // Ready from the wrong requester must not end the response.
    set_req(0, 5'b00100, 32'hF0F0_0000, 32'h0F0F_1234);
    wait_accept(0);
    rsp_ready = 2'b10;
    for (int i = 0; i < 4; i++) tick();
    check("wrong_ready_rsp_valid", rsp_valid, 2'b01);
    check("wrong_ready_busy", busy, 1'b1);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;

    // SUB and EQ from requester 1.
    set_req(1, 5'b01000, 32'd3, 32'd5);
    wait_accept(1);
    tick();
    check("sub_result", rsp_result, 32'hFFFF_FFFE);
    check("sub_owner", rsp_valid, 2'b10);
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    set_req(1, 5'b11000, 32'd9, 32'd9);
    wait_accept(1);
    tick();
    check("eq_flag", rsp_flag, 1'b1);
    check("eq_owner", rsp_valid, 2'b10);
    rsp_ready = 2'b10;
    tick();

    // Contention with both requesters always valid.
    rsp_ready = 2'b11;
    set_req(0, 5'b00000, 32'd100, 32'd1);
    set_req(1, 5'b00000, 32'd200, 32'd2);
    #1;
    got = 0;
    n = 0;
    while (got < 4 && n < 40) begin
      if (req_ready != '0) begin
        check("contention_grant", idx_of(8'(req_ready)), FIXED ? 0 : got % 2);
        got++;
      end
      tick();
      n++;
    end
    check("contention_count", got, 4);
    req_valid = '0;
    n = 0;
    while (busy && n < 10) begin
      tick();
      n++;
    end
    check("contention_drain", busy, 1'b0);
    rsp_ready = 2'b00;

    // Reset in the execute cycle aborts the operation.
    set_req(0, 5'b00000, 32'd1, 32'd1);
    wait_accept(0);
    rst = 1'b1;
    #1;
    check("rst_mid_rsp_valid", rsp_valid, 2'b00);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_result", rsp_result, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    set_req(1, 5'b00000, 32'd4, 32'd4);
    #1;
    check("rst_after_ready", req_ready, 2'b10);
    wait_accept(1);
    tick();
    check("rst_after_owner", rsp_valid, 2'b10);
    check("rst_after_result", rsp_result, 32'd8);
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;

    // Three requesters: pointer wrap.
    rr3 = 3'b111;
    op3 = '0;
    a3 = {32'd3, 32'd2, 32'd1};
    b3 = '0;
    valid3 = 3'b111;
    #1;
    got = 0;
    n = 0;
    while (got < 4 && n < 60) begin
      if (ready3 != '0) begin
        check("wrap_grant", idx_of(8'(ready3)), FIXED ? 0 : got % 3);
        got++;
      end
      if (rv3 != '0) check("wrap_result", res3, idx_of(8'(rv3)) + 1);
      tick();
      n++;
    end
    check("wrap_count", got, 4);
    valid3 = '0;
    for (int i = 0; i < 4; i++) tick();
    check("wrap_idle", busy3, 1'b0);

    // Randomized traffic; requesters hold valid and payload until accepted.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc = req_ready & req_valid;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (acc[k]) req_valid[k] = 1'b0;
        if (!req_valid[k] && $urandom_range(0, 2) == 0) begin
          logic [31:0] ra, rb;
          ra = $urandom;
          rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
          set_req(k, op_list[$urandom_range(0, 15)], ra, rb);
        end
      end
      rsp_ready = N'($urandom);
    end
    n = 0;
    while ((req_valid != '0 || busy) && n < 60) begin
      @(negedge clk);
      acc = req_ready & req_valid;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~acc;
      rsp_ready = '1;
      n++;
    end
    check("random_drain", {req_valid != '0, busy}, 2'b00);
    tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
